// File: rtl/axis_arb_pkg.sv
// Purpose: shared types and width helper for the frame-granular AXIS arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Bit width needed to hold values 0..value-1, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/axis_frame_arbiter_rr_select.sv
// Purpose: cyclic first-set search over a request vector, starting at ptr.
// Latency: purely combinational.
// Backpressure: none; found=0 when no request is set.
module rr_select #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req_vec,
    input  logic [IDX_W-1:0]  ptr,
    output logic [IDX_W-1:0]  grant_idx,
    output logic              found
);

    // Walk offsets from farthest to nearest so the nearest request at or above ptr wins.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int off = NUM_CH - 1; off >= 0; off--) begin
            cand = int'(ptr) + off;
            if (cand >= NUM_CH) begin
                cand = cand - NUM_CH;
            end
            cand_idx = IDX_W'(cand);
            if (req_vec[cand_idx]) begin
                grant_idx = cand_idx;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Purpose: round-robin arbiter granting one input channel the output for FRAME_LEN beats.
// Latency: 1 cycle arbitration in IDLE, then 1 cycle s_tdata -> m_tdata.
// Backpressure: s_tready of the granted channel = !m_tvalid || m_tready; all others held low.
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TDATA_WIDTH = 32,
    parameter int FRAME_LEN   = 1024
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_CH*TDATA_WIDTH-1:0] s_tdata,
    input  logic [NUM_CH-1:0]             s_tvalid,
    output logic [NUM_CH-1:0]             s_tready,
    output logic [TDATA_WIDTH-1:0]        m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [$clog2(NUM_CH)-1:0]     grant_idx,
    output logic                          busy
);

    localparam int                IDX_W    = clog2_min1(NUM_CH);
    localparam int                CNT_W    = clog2_min1(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CH - 1);

    arb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [TDATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
    logic                   m_tvalid_q, m_tvalid_d;

    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_found;
    logic                   out_free;
    logic                   beat_acc;
    logic [TDATA_WIDTH-1:0] beat_dat;

    rr_select #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr_select (
        .req_vec   (s_tvalid),
        .ptr       (ptr_q),
        .grant_idx (sel_idx),
        .found     (sel_found)
    );

    // Output slot can take a beat when empty or draining this cycle.
    assign out_free = !m_tvalid_q || m_tready;
    assign beat_acc = (state_q == BUSY) && out_free && s_tvalid[grant_q];

    // Only the granted channel sees ready, and only inside a frame.
    always_comb begin
        s_tready = '0;
        if (state_q == BUSY) begin
            s_tready[grant_q] = out_free;
        end
    end

    // Mux the granted channel's data lane.
    always_comb begin
        beat_dat = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (IDX_W'(k) == grant_q) begin
                beat_dat = s_tdata[k*TDATA_WIDTH +: TDATA_WIDTH];
            end
        end
    end

    // Arbitration FSM: pick a channel in IDLE, count its beats in BUSY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_idx;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (beat_acc) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        ptr_d   = (grant_q == IDX_LAST) ? '0 : grant_q + 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: load on accept, clear on drain, otherwise hold for AXIS stability.
    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        if (beat_acc) begin
            m_tdata_d  = beat_dat;
            m_tvalid_d = 1'b1;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    // State registers; reset aborts any frame in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            grant_q    <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q == BUSY);

endmodule
